// File: rtl/lsu.sv
// Multi-cycle load/store unit between the ALU address path and a synchronous byte-lane SRAM.
// Misaligned accesses that cross a word boundary are split into two beats or faulted (MISALIGN).
module lsu_lane #(
  parameter int LANE = 0,
  parameter int NB   = 4,
  parameter int EW   = 4
) (
  input  logic [EW-1:0] off,
  input  logic [EW-1:0] endb,
  input  logic [EW-1:0] nbytes,
  input  logic          beat1,
  input  logic [7:0]    sbyte,
  input  logic          fill,
  output logic          en,
  output logic [7:0]    dbyte
);
  localparam logic [EW-1:0] LO = EW'(LANE);
  localparam logic [EW-1:0] HI = EW'(LANE + NB);

  // beat 1 covers the bytes that spilled past the end of the first word
  assign en    = beat1 ? (HI < endb) : ((off <= LO) && (LO < endb));
  assign dbyte = (LO < nbytes) ? sbyte : {8{fill}};
endmodule

module lsu #(
  parameter int XLEN     = 32,
  parameter int ADDR_W   = 17,
  parameter int MISALIGN = 1
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                req_valid,
  output logic                                req_ready,
  input  logic                                req_store,
  input  logic [1:0]                          req_size,
  input  logic                                req_unsigned,
  input  logic [ADDR_W-1:0]                   req_addr,
  input  logic [XLEN-1:0]                     req_wdata,
  output logic                                rsp_valid,
  input  logic                                rsp_ready,
  output logic [XLEN-1:0]                     rsp_data,
  output logic                                rsp_fault,
  output logic                                mem_cs_n,
  output logic                                mem_we_n,
  output logic [XLEN/8-1:0]                   mem_be_n,
  output logic [ADDR_W-$clog2(XLEN/8)-1:0]    mem_addr,
  output logic [XLEN-1:0]                     mem_wdata,
  input  logic [XLEN-1:0]                     mem_rdata
);
  localparam int NB = XLEN / 8;
  localparam int OW = $clog2(NB);
  localparam int WW = ADDR_W - OW;
  localparam int EW = OW + 2;

  typedef enum logic [1:0] {IDLE, ACC0, ACC1, RESP} state_t;
  state_t state, nxt;

  logic            store, uns, split, fault;
  logic [1:0]      size;
  logic [XLEN-1:0] wdata, lo;
  logic [OW-1:0]   off;
  logic [WW-1:0]   word;
  logic [EW-1:0]   nbytes;

  logic [OW-1:0]   off_in;
  logic [EW-1:0]   nb_in;
  logic            split_in, fault_in, accept;

  assign off_in   = req_addr[OW-1:0];
  assign nb_in    = EW'(1) << req_size;
  assign split_in = (EW'(off_in) + nb_in) > EW'(NB);
  assign fault_in = (split_in && (MISALIGN == 0)) || ((req_size == 2'd3) && (XLEN == 32));
  assign accept   = req_valid && req_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= nxt;
  end

  logic [NB-1:0] lane_en;

  always_comb begin
    nxt       = state;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    mem_cs_n  = 1'b1;
    mem_we_n  = 1'b1;
    mem_be_n  = '1;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) nxt = fault_in ? RESP : ACC0;
      end
      ACC0: begin
        mem_cs_n = 1'b0;
        mem_we_n = !store;
        mem_be_n = ~lane_en;
        nxt      = split ? ACC1 : RESP;
      end
      ACC1: begin
        mem_cs_n = 1'b0;
        mem_we_n = !store;
        mem_be_n = ~lane_en;
        nxt      = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        req_ready = rsp_ready;
        if (rsp_ready) nxt = req_valid ? (fault_in ? RESP : ACC0) : IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      store  <= 1'b0;
      size   <= '0;
      uns    <= 1'b0;
      wdata  <= '0;
      off    <= '0;
      word   <= '0;
      nbytes <= '0;
      split  <= 1'b0;
      fault  <= 1'b0;
      lo     <= '0;
    end else begin
      if (accept) begin
        store  <= req_store;
        size   <= req_size;
        uns    <= req_unsigned;
        wdata  <= req_wdata;
        off    <= off_in;
        word   <= req_addr[ADDR_W-1:OW];
        nbytes <= nb_in;
        split  <= split_in;
        fault  <= fault_in;
      end
      // beat-0 read data arrives during ACC1 and would be overwritten by beat 1
      if (state == ACC1) lo <= mem_rdata;
    end
  end

  logic [2*XLEN-1:0] rot, dbl, shd;
  logic [XLEN-1:0]   ldata;
  logic [EW-1:0]     off_e, endb;
  logic              sign;

  assign off_e     = EW'(off);
  assign endb      = off_e + nbytes;
  assign rot       = {wdata, wdata} << {off, 3'b000};
  assign mem_wdata = rot[2*XLEN-1:XLEN];
  assign mem_addr  = (state == ACC1) ? word + WW'(1) : word;

  assign dbl = split ? {mem_rdata, lo} : {{XLEN{1'b0}}, mem_rdata};
  assign shd = dbl >> {off, 3'b000};

  always_comb begin
    case (size)
      2'd0:    sign = shd[7];
      2'd1:    sign = shd[15];
      2'd2:    sign = shd[31];
      default: sign = shd[63];
    endcase
  end

  for (genvar i = 0; i < NB; i++) begin : g_lane
    lsu_lane #(.LANE(i), .NB(NB), .EW(EW)) u_lane (
      .off    (off_e),
      .endb   (endb),
      .nbytes (nbytes),
      .beat1  (state == ACC1),
      .sbyte  (shd[8*i +: 8]),
      .fill   (sign & ~uns),
      .en     (lane_en[i]),
      .dbyte  (ldata[8*i +: 8])
    );
  end

  assign rsp_fault = (state == RESP) && fault;
  assign rsp_data  = ((state == RESP) && !store && !fault) ? ldata : '0;
endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu: one split-capable instance with an SRAM model, one faulting instance.
module tb_lsu;
  localparam int XLEN = 32, ADDR_W = 17, NB = 4, WW = 15;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic              req_valid, req_ready, req_store, req_unsigned;
  logic [1:0]        req_size;
  logic [ADDR_W-1:0] req_addr;
  logic [XLEN-1:0]   req_wdata, rsp_data, mem_wdata, mem_rdata;
  logic              rsp_valid, rsp_ready, rsp_fault, mem_cs_n, mem_we_n;
  logic [NB-1:0]     mem_be_n;
  logic [WW-1:0]     mem_addr;

  logic              f_req_valid, f_req_ready, f_req_store, f_req_unsigned;
  logic [1:0]        f_req_size;
  logic [ADDR_W-1:0] f_req_addr;
  logic [XLEN-1:0]   f_req_wdata, f_rsp_data, f_mem_wdata, f_mem_rdata;
  logic              f_rsp_valid, f_rsp_ready, f_rsp_fault, f_mem_cs_n, f_mem_we_n;
  logic [NB-1:0]     f_mem_be_n;
  logic [WW-1:0]     f_mem_addr;

  assign f_mem_rdata = '0;

  lsu #(.XLEN(XLEN), .ADDR_W(ADDR_W), .MISALIGN(1)) u_dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_fault(rsp_fault),
    .mem_cs_n(mem_cs_n), .mem_we_n(mem_we_n), .mem_be_n(mem_be_n), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata));

  lsu #(.XLEN(XLEN), .ADDR_W(ADDR_W), .MISALIGN(0)) u_flt (
    .clk(clk), .rst(rst), .req_valid(f_req_valid), .req_ready(f_req_ready), .req_store(f_req_store),
    .req_size(f_req_size), .req_unsigned(f_req_unsigned), .req_addr(f_req_addr), .req_wdata(f_req_wdata),
    .rsp_valid(f_rsp_valid), .rsp_ready(f_rsp_ready), .rsp_data(f_rsp_data), .rsp_fault(f_rsp_fault),
    .mem_cs_n(f_mem_cs_n), .mem_we_n(f_mem_we_n), .mem_be_n(f_mem_be_n), .mem_addr(f_mem_addr),
    .mem_wdata(f_mem_wdata), .mem_rdata(f_mem_rdata));

  // SRAM model with a backdoor write port for preloading
  logic [XLEN-1:0] mem [0:(1<<WW)-1];
  logic            bd_we = 1'b0;
  logic [WW-1:0]   bd_addr;
  logic [XLEN-1:0] bd_data;

  always @(posedge clk) begin
    if (bd_we) mem[bd_addr] <= bd_data;
    else if (!mem_cs_n) begin
      if (!mem_we_n) begin
        for (int i = 0; i < NB; i++)
          if (!mem_be_n[i]) mem[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
      end else mem_rdata <= mem[mem_addr];
    end
  end

  int vecs = 0, errs = 0;

  task automatic poke(input logic [WW-1:0] a, input logic [XLEN-1:0] d);
    bd_addr = a; bd_data = d; bd_we = 1'b1;
    @(posedge clk); #1 bd_we = 1'b0;
    @(negedge clk);
  endtask

  task automatic drive(input logic st, input logic [1:0] sz, input logic un,
                       input logic [ADDR_W-1:0] a, input logic [XLEN-1:0] wd);
    req_store = st; req_size = sz; req_unsigned = un; req_addr = a; req_wdata = wd; req_valid = 1'b1;
    @(posedge clk); #1 req_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #3;
    vecs++; if (req_ready !== 1'b1) begin errs++; $display("FAIL rst_req_ready got %b exp 1", req_ready); end
    vecs++; if (rsp_valid !== 1'b0) begin errs++; $display("FAIL rst_rsp_valid got %b exp 0", rsp_valid); end
    vecs++; if (rsp_data !== 32'h0) begin errs++; $display("FAIL rst_rsp_data got %h exp 0", rsp_data); end
    vecs++; if (rsp_fault !== 1'b0) begin errs++; $display("FAIL rst_rsp_fault got %b exp 0", rsp_fault); end
    vecs++; if (mem_cs_n !== 1'b1) begin errs++; $display("FAIL rst_cs_n got %b exp 1", mem_cs_n); end
    vecs++; if (mem_we_n !== 1'b1) begin errs++; $display("FAIL rst_we_n got %b exp 1", mem_we_n); end
    vecs++; if (mem_be_n !== 4'hF) begin errs++; $display("FAIL rst_be_n got %b exp 1111", mem_be_n); end
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    vecs++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin errs++;
      $display("FAIL post_rst_idle got ready=%b valid=%b exp 1/0", req_ready, rsp_valid); end
  endtask

  task automatic test_aligned_load();
    poke(15'd5, 32'h8899AABB);
    drive(1'b0, 2'd2, 1'b0, 17'h14, 32'h0);
    @(negedge clk);
    vecs++; if ({mem_cs_n, mem_we_n} !== 2'b01) begin errs++; $display("FAIL lw_cs_we got %b exp 01", {mem_cs_n, mem_we_n}); end
    vecs++; if (mem_addr !== 15'd5) begin errs++; $display("FAIL lw_addr got %h exp 5", mem_addr); end
    vecs++; if (mem_be_n !== 4'b0000) begin errs++; $display("FAIL lw_be got %b exp 0000", mem_be_n); end
    vecs++; if (rsp_valid !== 1'b0) begin errs++; $display("FAIL lw_early_valid got %b exp 0", rsp_valid); end
    @(negedge clk);
    vecs++; if (rsp_valid !== 1'b1 || rsp_fault !== 1'b0) begin errs++;
      $display("FAIL lw_rsp got valid=%b fault=%b exp 1/0", rsp_valid, rsp_fault); end
    vecs++; if (rsp_data !== 32'h8899AABB) begin errs++; $display("FAIL lw_data got %h exp 8899aabb", rsp_data); end
    @(negedge clk);
    vecs++; if (rsp_valid !== 1'b0 || mem_cs_n !== 1'b1) begin errs++;
      $display("FAIL lw_idle got valid=%b cs_n=%b exp 0/1", rsp_valid, mem_cs_n); end
  endtask

  task automatic test_byte_half();
    logic [1:0]        sz [4] = '{2'd0, 2'd0, 2'd1, 2'd1};
    logic              un [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [ADDR_W-1:0] ad [4] = '{17'h17, 17'h17, 17'h16, 17'h15};
    logic [3:0]        be [4] = '{4'b0111, 4'b0111, 4'b0011, 4'b1001};
    logic [XLEN-1:0]   ex [4] = '{32'hFFFFFF88, 32'h00000088, 32'hFFFF8899, 32'h000099AA};
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, sz[k], un[k], ad[k], 32'h0);
      @(negedge clk);
      vecs++; if (mem_be_n !== be[k]) begin errs++; $display("FAIL bh%0d_be got %b exp %b", k, mem_be_n, be[k]); end
      @(negedge clk);
      vecs++; if (rsp_data !== ex[k]) begin errs++; $display("FAIL bh%0d_data got %h exp %h", k, rsp_data, ex[k]); end
      @(negedge clk);
    end
  endtask

  task automatic test_split_load();
    poke(15'd5, 32'h44332211);
    poke(15'd6, 32'h88776655);
    drive(1'b0, 2'd2, 1'b0, 17'h17, 32'h0);
    @(negedge clk);
    vecs++; if (mem_cs_n !== 1'b0 || mem_addr !== 15'd5 || mem_be_n !== 4'b0111) begin errs++;
      $display("FAIL sl_beat0 got cs_n=%b addr=%h be=%b exp 0/5/0111", mem_cs_n, mem_addr, mem_be_n); end
    @(negedge clk);
    vecs++; if (mem_cs_n !== 1'b0 || mem_addr !== 15'd6 || mem_be_n !== 4'b1000) begin errs++;
      $display("FAIL sl_beat1 got cs_n=%b addr=%h be=%b exp 0/6/1000", mem_cs_n, mem_addr, mem_be_n); end
    vecs++; if (rsp_valid !== 1'b0) begin errs++; $display("FAIL sl_early_valid got %b exp 0", rsp_valid); end
    @(negedge clk);
    vecs++; if (rsp_valid !== 1'b1 || rsp_data !== 32'h77665544) begin errs++;
      $display("FAIL sl_data got valid=%b data=%h exp 1/77665544", rsp_valid, rsp_data); end
    @(negedge clk);
  endtask

  task automatic test_split_store();
    drive(1'b1, 2'd2, 1'b0, 17'h16, 32'hDEADBEEF);
    @(negedge clk);
    vecs++; if (mem_we_n !== 1'b0 || mem_addr !== 15'd5 || mem_be_n !== 4'b0011) begin errs++;
      $display("FAIL ss_beat0 got we_n=%b addr=%h be=%b exp 0/5/0011", mem_we_n, mem_addr, mem_be_n); end
    vecs++; if (mem_wdata !== 32'hBEEFDEAD) begin errs++; $display("FAIL ss_wdata got %h exp beefdead", mem_wdata); end
    @(negedge clk);
    vecs++; if (mem_we_n !== 1'b0 || mem_addr !== 15'd6 || mem_be_n !== 4'b1100) begin errs++;
      $display("FAIL ss_beat1 got we_n=%b addr=%h be=%b exp 0/6/1100", mem_we_n, mem_addr, mem_be_n); end
    @(negedge clk);
    vecs++; if (rsp_valid !== 1'b1 || rsp_data !== 32'h0) begin errs++;
      $display("FAIL ss_rsp got valid=%b data=%h exp 1/0", rsp_valid, rsp_data); end
    @(negedge clk);
    vecs++; if (mem[5] !== 32'hBEEF2211) begin errs++; $display("FAIL ss_word5 got %h exp beef2211", mem[5]); end
    vecs++; if (mem[6] !== 32'h8877DEAD) begin errs++; $display("FAIL ss_word6 got %h exp 8877dead", mem[6]); end
    drive(1'b0, 2'd2, 1'b0, 17'h16, 32'h0);
    repeat (3) @(negedge clk);
    vecs++; if (rsp_data !== 32'hDEADBEEF) begin errs++; $display("FAIL ss_readback got %h exp deadbeef", rsp_data); end
    @(negedge clk);
    poke(15'd0, 32'h0);
    poke(15'h7FFF, 32'h0);
    drive(1'b1, 2'd1, 1'b0, 17'h1FFFF, 32'h00001234);
    @(negedge clk);
    vecs++; if (mem_addr !== 15'h7FFF || mem_be_n !== 4'b0111) begin errs++;
      $display("FAIL wrap_beat0 got addr=%h be=%b exp 7fff/0111", mem_addr, mem_be_n); end
    @(negedge clk);
    vecs++; if (mem_addr !== 15'd0 || mem_be_n !== 4'b1110) begin errs++;
      $display("FAIL wrap_beat1 got addr=%h be=%b exp 0/1110", mem_addr, mem_be_n); end
    repeat (2) @(negedge clk);
    vecs++; if (mem[0] !== 32'h00000012) begin errs++; $display("FAIL wrap_word0 got %h exp 00000012", mem[0]); end
    vecs++; if (mem[32767] !== 32'h34000000) begin errs++; $display("FAIL wrap_top got %h exp 34000000", mem[32767]); end
  endtask

  task automatic test_fault();
    drive(1'b0, 2'd3, 1'b0, 17'h10, 32'h0);
    @(negedge clk);
    vecs++; if (rsp_valid !== 1'b1 || rsp_fault !== 1'b1 || rsp_data !== 32'h0 || mem_cs_n !== 1'b1) begin errs++;
      $display("FAIL dsize_fault got valid=%b fault=%b data=%h cs_n=%b exp 1/1/0/1", rsp_valid, rsp_fault, rsp_data, mem_cs_n); end
    @(negedge clk);
    f_req_store = 1'b0; f_req_size = 2'd2; f_req_unsigned = 1'b0; f_req_addr = 17'h17; f_req_valid = 1'b1;
    @(posedge clk); #1 f_req_valid = 1'b0;
    vecs++; if (f_mem_cs_n !== 1'b1) begin errs++; $display("FAIL mis_cs_n got %b exp 1", f_mem_cs_n); end
    @(negedge clk);
    vecs++; if (f_rsp_valid !== 1'b1 || f_rsp_fault !== 1'b1 || f_rsp_data !== 32'h0) begin errs++;
      $display("FAIL mis_fault got valid=%b fault=%b data=%h exp 1/1/0", f_rsp_valid, f_rsp_fault, f_rsp_data); end
    @(negedge clk);
    vecs++; if (f_mem_cs_n !== 1'b1 || f_rsp_valid !== 1'b0) begin errs++;
      $display("FAIL mis_after got cs_n=%b valid=%b exp 1/0", f_mem_cs_n, f_rsp_valid); end
    f_req_size = 2'd3; f_req_addr = 17'h10; f_req_valid = 1'b1;
    @(posedge clk); #1 f_req_valid = 1'b0;
    @(negedge clk);
    vecs++; if (f_rsp_fault !== 1'b1 || f_mem_cs_n !== 1'b1) begin errs++;
      $display("FAIL f_dsize got fault=%b cs_n=%b exp 1/1", f_rsp_fault, f_mem_cs_n); end
    @(negedge clk);
    f_req_size = 2'd1; f_req_addr = 17'h15; f_req_valid = 1'b1;
    @(posedge clk); #1 f_req_valid = 1'b0;
    @(negedge clk);
    vecs++; if (f_mem_cs_n !== 1'b0 || f_mem_be_n !== 4'b1001) begin errs++;
      $display("FAIL f_inword got cs_n=%b be=%b exp 0/1001", f_mem_cs_n, f_mem_be_n); end
    @(negedge clk);
    vecs++; if (f_rsp_valid !== 1'b1 || f_rsp_fault !== 1'b0) begin errs++;
      $display("FAIL f_inword_rsp got valid=%b fault=%b exp 1/0", f_rsp_valid, f_rsp_fault); end
    @(negedge clk);
  endtask

  task automatic test_handshake();
    rsp_ready = 1'b0;
    drive(1'b0, 2'd2, 1'b0, 17'h14, 32'h0);
    repeat (2) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      vecs++; if (rsp_valid !== 1'b1 || rsp_data !== 32'hBEEF2211 || req_ready !== 1'b0 || mem_cs_n !== 1'b1) begin errs++;
        $display("FAIL stall%0d got valid=%b data=%h ready=%b cs_n=%b exp 1/beef2211/0/1", k, rsp_valid, rsp_data, req_ready, mem_cs_n); end
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    vecs++; if (rsp_valid !== 1'b0) begin errs++; $display("FAIL stall_release got %b exp 0", rsp_valid); end
  endtask

  task automatic test_back_to_back();
    drive(1'b0, 2'd2, 1'b0, 17'h14, 32'h0);
    repeat (2) @(negedge clk);
    vecs++; if (rsp_valid !== 1'b1 || req_ready !== 1'b1) begin errs++;
      $display("FAIL b2b_resp got valid=%b ready=%b exp 1/1", rsp_valid, req_ready); end
    drive(1'b0, 2'd0, 1'b1, 17'h17, 32'h0);
    @(negedge clk);
    vecs++; if (mem_cs_n !== 1'b0 || mem_be_n !== 4'b0111 || rsp_valid !== 1'b0) begin errs++;
      $display("FAIL b2b_acc0 got cs_n=%b be=%b valid=%b exp 0/0111/0", mem_cs_n, mem_be_n, rsp_valid); end
    @(negedge clk);
    vecs++; if (rsp_data !== 32'h000000BE) begin errs++; $display("FAIL b2b_data got %h exp 000000be", rsp_data); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    drive(1'b0, 2'd2, 1'b0, 17'h17, 32'h0);
    @(negedge clk);
    @(posedge clk); #2;
    vecs++; if (mem_cs_n !== 1'b0 || mem_addr !== 15'd6) begin errs++;
      $display("FAIL rm_acc1 got cs_n=%b addr=%h exp 0/6", mem_cs_n, mem_addr); end
    rst = 1'b0;
    #1;
    vecs++; if (mem_cs_n !== 1'b1 || mem_be_n !== 4'hF || mem_we_n !== 1'b1) begin errs++;
      $display("FAIL rm_async got cs_n=%b be=%b we_n=%b exp 1/1111/1", mem_cs_n, mem_be_n, mem_we_n); end
    @(negedge clk);
    vecs++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_data !== 32'h0) begin errs++;
      $display("FAIL rm_state got ready=%b valid=%b data=%h exp 1/0/0", req_ready, rsp_valid, rsp_data); end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    vecs++; if (rsp_valid !== 1'b0 || mem_cs_n !== 1'b1) begin errs++;
      $display("FAIL rm_discard got valid=%b cs_n=%b exp 0/1", rsp_valid, mem_cs_n); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    req_valid = 1'b0; req_store = 1'b0; req_size = 2'd0; req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
    rsp_ready = 1'b1;
    f_req_valid = 1'b0; f_req_store = 1'b0; f_req_size = 2'd0; f_req_unsigned = 1'b0; f_req_addr = '0; f_req_wdata = '0;
    f_rsp_ready = 1'b1;
    bd_addr = '0; bd_data = '0;
    test_reset();
    test_aligned_load();
    test_byte_half();
    test_split_load();
    test_split_store();
    test_fault();
    test_handshake();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
